// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg: state, opcode and control-field encodings shared by the multicycle controller
package risc_ctrl_pkg;
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        CL_R, CL_ADDI, CL_ANDI, CL_ORI, CL_LUI, CL_LW, CL_SW, CL_BEQ, CL_J, CL_HALT, CL_ILL
    } op_class_t;
endpackage

// File: rtl/ctrl_opcode_decode.sv
// ctrl_opcode_decode: classifies an opcode and derives its extender mode, ALU op and legality
module ctrl_opcode_decode import risc_ctrl_pkg::*; #(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] op,
    output op_class_t        cls,
    output logic [1:0]       ext_mode,
    output logic [2:0]       alu_op,
    output logic             legal
);
    always_comb begin
        case (op)
            OPC_W'(OP_R):    cls = CL_R;
            OPC_W'(OP_ADDI): cls = CL_ADDI;
            OPC_W'(OP_ANDI): cls = CL_ANDI;
            OPC_W'(OP_ORI):  cls = CL_ORI;
            OPC_W'(OP_LUI):  cls = CL_LUI;
            OPC_W'(OP_LW):   cls = CL_LW;
            OPC_W'(OP_SW):   cls = CL_SW;
            OPC_W'(OP_BEQ):  cls = CL_BEQ;
            OPC_W'(OP_J):    cls = CL_J;
            OPC_W'(OP_HALT): cls = CL_HALT;
            default:         cls = CL_ILL;
        endcase
    end

    assign ext_mode = (cls == CL_ANDI || cls == CL_ORI) ? EXT_ZERO :
                      cls == CL_LUI                     ? EXT_UPPER : EXT_SIGN;
    // LUI is computed as r0 | (imm16 << 16)
    assign alu_op   = cls == CL_R                       ? ALU_FUNCT :
                      cls == CL_BEQ                     ? ALU_SUB :
                      cls == CL_ANDI                    ? ALU_AND :
                      (cls == CL_ORI || cls == CL_LUI)  ? ALU_OR : ALU_ADD;
    assign legal    = cls != CL_ILL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer with a shared req/ack memory port
module multicycle_ctrl import risc_ctrl_pkg::*; #(
    parameter int OPC_W   = 6,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       ext_mode,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_error
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]       state, next;
    logic [OPC_W-1:0] op_q, dec_op;
    logic [CNT_W-1:0] cnt;
    op_class_t        cls;
    logic [1:0]       dec_ext;
    logic [2:0]       dec_alu;
    logic             legal, wait_st, expired, exec, uses_imm;

    // IR is only valid from DECODE on, so decode the live opcode there and the latched copy afterwards
    assign dec_op = state == S_DECODE ? opcode : op_q;

    ctrl_opcode_decode #(.OPC_W(OPC_W)) u_dec (
        .op       (dec_op),
        .cls      (cls),
        .ext_mode (dec_ext),
        .alu_op   (dec_alu),
        .legal    (legal)
    );

    assign wait_st  = state == S_FETCH || state == S_MEM;
    assign expired  = wait_st && !mem_ack && cnt == CNT_W'(TIMEOUT - 1);
    assign exec     = state == S_EXEC;
    assign uses_imm = cls inside {CL_ADDI, CL_ANDI, CL_ORI, CL_LUI, CL_LW, CL_SW};

    always_comb begin
        next = state;
        case (state)
            S_FETCH:  next = mem_ack ? S_DECODE : expired ? S_HALT : S_FETCH;
            S_DECODE: next = cls == CL_HALT ? S_HALT : legal ? S_EXEC : S_FETCH;
            S_EXEC:   next = (cls == CL_LW || cls == CL_SW) ? S_MEM :
                             (cls == CL_BEQ || cls == CL_J) ? S_FETCH : S_WB;
            S_MEM:    next = mem_ack ? (cls == CL_LW ? S_WB : S_FETCH) : expired ? S_HALT : S_MEM;
            S_WB:     next = S_FETCH;
            default:  next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            op_q      <= '0;
            cnt       <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE)
                op_q <= opcode;
            cnt <= (wait_st && !mem_ack && next == state) ? cnt + 1'b1 : '0;
            if (expired)
                bus_error <= 1'b1;
        end
    end

    // rst_n gates every output so an abandoned request vanishes the moment reset asserts
    assign mem_req    = rst_n && wait_st;
    assign mem_we     = rst_n && state == S_MEM && cls == CL_SW;
    assign ir_write   = rst_n && state == S_FETCH && mem_ack;
    assign pc_write   = ir_write || (rst_n && exec && (cls == CL_J || (cls == CL_BEQ && alu_zero)));
    assign pc_src     = !(rst_n && exec) ? PCSRC_SEQ : cls == CL_J ? PCSRC_JMP :
                        cls == CL_BEQ ? PCSRC_BR : PCSRC_SEQ;
    assign ext_mode   = rst_n && state inside {S_DECODE, S_EXEC, S_MEM, S_WB} ? dec_ext : EXT_SIGN;
    assign alu_src_b  = !rst_n ? SRCB_RT : state == S_FETCH ? SRCB_FOUR :
                        exec && uses_imm ? SRCB_IMM : SRCB_RT;
    assign alu_op     = rst_n && exec ? dec_alu : ALU_ADD;
    assign reg_dst    = rst_n && state == S_WB && cls == CL_R;
    assign mem_to_reg = rst_n && state == S_WB && cls == CL_LW;
    assign reg_write  = rst_n && state == S_WB;
    assign halted     = rst_n && state == S_HALT;
    assign illegal_op = rst_n && state == S_DECODE && !legal;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed cycle-by-cycle check of every controller output with TIMEOUT=4
module tb_multicycle_ctrl;
    logic       clk, rst_n, alu_zero, mem_ack;
    logic [5:0] opcode;
    logic       mem_req, mem_we, ir_write, pc_write, reg_dst, mem_to_reg, reg_write;
    logic       halted, illegal_op, bus_error;
    logic [1:0] pc_src, ext_mode, alu_src_b;
    logic [2:0] alu_op;
    logic [18:0] sig;
    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.OPC_W(6), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .alu_zero   (alu_zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ext_mode   (ext_mode),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .halted     (halted),
        .illegal_op (illegal_op),
        .bus_error  (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sig = {mem_req, mem_we, ir_write, pc_write, pc_src, ext_mode, alu_src_b, alu_op,
                  reg_dst, mem_to_reg, reg_write, halted, illegal_op, bus_error};

    task automatic cyc(input logic r, input logic ack, input logic [5:0] opc, input logic z);
        @(negedge clk);
        rst_n    = r;
        mem_ack  = ack;
        opcode   = opc;
        alu_zero = z;
        #1;
    endtask

    task automatic ex(input string tag, input logic mq, we, iw, pw, input logic [1:0] ps, em, sb,
                      input logic [2:0] ao, input logic rd, mr, rw, hl, il, be);
        logic [18:0] e;
        e = {mq, we, iw, pw, ps, em, sb, ao, rd, mr, rw, hl, il, be};
        checks++;
        assert (sig === e) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, sig, e);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; opcode = '0; alu_zero = 1'b0;
        cyc(0, 1, 6'h08, 0); ex("reset_hold",  0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        // ADDI, zero-wait memory
        cyc(1, 1, 6'h08, 0); ex("addi_fetch",  1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h08, 0); ex("addi_dec",    0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h08, 0); ex("addi_exec",   0,0,0,0, 0,0,1, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h08, 0); ex("addi_wb",     0,0,0,0, 0,0,0, 0, 0,0,1,0,0,0);
        // ORI then LUI
        cyc(1, 1, 6'h0D, 0); ex("ori_fetch",   1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h0D, 0); ex("ori_dec",     0,0,0,0, 0,1,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h0D, 0); ex("ori_exec",    0,0,0,0, 0,1,1, 3, 0,0,0,0,0,0);
        cyc(1, 1, 6'h0D, 0); ex("ori_wb",      0,0,0,0, 0,1,0, 0, 0,0,1,0,0,0);
        cyc(1, 1, 6'h0F, 0); ex("lui_fetch",   1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h0F, 0); ex("lui_dec",     0,0,0,0, 0,2,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h0F, 0); ex("lui_exec",    0,0,0,0, 0,2,1, 3, 0,0,0,0,0,0);
        cyc(1, 1, 6'h0F, 0); ex("lui_wb",      0,0,0,0, 0,2,0, 0, 0,0,1,0,0,0);
        // LW: 3 wait cycles in FETCH (ack lands in the timeout cycle), 2 in MEM
        cyc(1, 0, 6'h23, 0); ex("lw_fwait1",   1,0,0,0, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h23, 0); ex("lw_fwait2",   1,0,0,0, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h23, 0); ex("lw_fwait3",   1,0,0,0, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h23, 0); ex("lw_fack",     1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h23, 0); ex("lw_dec",      0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h23, 0); ex("lw_exec",     0,0,0,0, 0,0,1, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h23, 0); ex("lw_mwait1",   1,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h23, 0); ex("lw_mwait2",   1,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h23, 0); ex("lw_mack",     1,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h23, 0); ex("lw_wb",       0,0,0,0, 0,0,0, 0, 0,1,1,0,0,0);
        // BEQ taken / not taken, J
        cyc(1, 1, 6'h04, 0); ex("beq1_fetch",  1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h04, 0); ex("beq1_dec",    0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h04, 1); ex("beq1_exec",   0,0,0,1, 1,0,0, 1, 0,0,0,0,0,0);
        cyc(1, 1, 6'h04, 0); ex("beq0_fetch",  1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h04, 0); ex("beq0_dec",    0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h04, 0); ex("beq0_exec",   0,0,0,0, 1,0,0, 1, 0,0,0,0,0,0);
        cyc(1, 1, 6'h02, 0); ex("j_fetch",     1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h02, 0); ex("j_dec",       0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h02, 0); ex("j_exec",      0,0,0,1, 2,0,0, 0, 0,0,0,0,0,0);
        // SW goes straight back to FETCH, then an R-type
        cyc(1, 1, 6'h2B, 0); ex("sw_fetch",    1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h2B, 0); ex("sw_dec",      0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h2B, 0); ex("sw_exec",     0,0,0,0, 0,0,1, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h2B, 0); ex("sw_mem",      1,1,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h00, 0); ex("r_fetch",     1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h00, 0); ex("r_dec",       0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h00, 0); ex("r_exec",      0,0,0,0, 0,0,0, 7, 0,0,0,0,0,0);
        cyc(1, 1, 6'h00, 0); ex("r_wb",        0,0,0,0, 0,0,0, 0, 1,0,1,0,0,0);
        // illegal opcode pulses once and returns to FETCH
        cyc(1, 1, 6'h3A, 0); ex("ill_fetch",   1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h3A, 0); ex("ill_dec",     0,0,0,0, 0,0,0, 0, 0,0,0,0,1,0);
        cyc(1, 1, 6'h23, 0); ex("ill_refetch", 1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        // reset in the middle of a MEM request
        cyc(1, 1, 6'h23, 0); ex("rm_dec",      0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h23, 0); ex("rm_exec",     0,0,0,0, 0,0,1, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h23, 0); ex("rm_mwait",    1,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        rst_n = 1'b0; #1;    ex("rm_drop",     0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(0, 0, 6'h23, 0); ex("rm_hold",     0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        // no ack ever: 4 FETCH cycles then bus error and HALT
        cyc(1, 0, 6'h00, 0); ex("to_f1",       1,0,0,0, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h00, 0); ex("to_f2",       1,0,0,0, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h00, 0); ex("to_f3",       1,0,0,0, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h00, 0); ex("to_f4",       1,0,0,0, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 0, 6'h00, 0); ex("to_halt",     0,0,0,0, 0,0,0, 0, 0,0,0,1,0,1);
        cyc(1, 1, 6'h08, 0); ex("to_stuck1",   0,0,0,0, 0,0,0, 0, 0,0,0,1,0,1);
        cyc(1, 1, 6'h23, 0); ex("to_stuck2",   0,0,0,0, 0,0,0, 0, 0,0,0,1,0,1);
        cyc(0, 1, 6'h23, 0); ex("to_reset",    0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        // HALT opcode
        cyc(1, 1, 6'h3F, 0); ex("halt_fetch",  1,0,1,1, 0,0,2, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h3F, 0); ex("halt_dec",    0,0,0,0, 0,0,0, 0, 0,0,0,0,0,0);
        cyc(1, 1, 6'h08, 0); ex("halt_state",  0,0,0,0, 0,0,0, 0, 0,0,0,1,0,0);
        cyc(1, 1, 6'h08, 0); ex("halt_stay",   0,0,0,0, 0,0,0, 0, 0,0,0,1,0,0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
